// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants and the FCS checker state encoding.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The CRC is shifted LSB-first, so the update uses the bit-reversed polynomial.
  localparam logic [31:0] CRC32_POLY_REFL = bitrev32(CRC32_POLY);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } fcs_state_e;

  typedef struct packed {
    logic oversize;
    logic runt;
    logic fcs_err;
    logic good;
  } fcs_stat_t;

endpackage

// File: rtl/eth_fcs_check_if.sv
// Byte-wide AXI-Stream style link with frame-error sideband (tuser).
interface eth_fcs_check_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32; purely combinational so TX and RX can share it.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    // NOTE: blocking assignments here build an 8-step combinational chain; each
    // iteration must see the value produced by the previous one.
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_fcs_check.sv
// Receive-side FCS checker: strips the 4-byte FCS through a delay line, flags bad,
// runt and oversize frames on the output tlast beat and pulses one statistic per frame.
module eth_fcs_check
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic            clk,
  input  logic            rst,
  eth_fcs_check_if.slave  s_axis,
  eth_fcs_check_if.master m_axis,
  output logic            stat_frame_good,
  output logic            stat_fcs_err,
  output logic            stat_runt,
  output logic            stat_oversize
);

  fcs_state_e            state_q, state_d;
  logic [2:0]            fill_q, fill_d;
  logic [15:0]           count_q, count_d, count_inc;
  logic [31:0]           crc_q, crc_d, crc_next;
  logic                  sticky_q, sticky_d, sticky_in;
  logic [DATA_WIDTH-1:0] dl_q [4];
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic                  m_tuser_q, m_tuser_d;
  fcs_stat_t             stat_q, stat_d;
  logic                  s_ready, accept, bad_fcs, runt, oversize_hit, shift_en;

  eth_crc32_d8 u_crc (
    .crc_in (crc_q),
    .data   (s_axis.tdata),
    .crc_out(crc_next)
  );

  assign s_ready      = (state_q == ST_DROP) || !m_tvalid_q || m_axis.tready;
  assign accept       = s_axis.tvalid && s_ready;
  assign count_inc    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  assign sticky_in    = sticky_q | s_axis.tuser;
  assign bad_fcs      = (crc_next != CRC32_RESIDUE);
  assign runt         = (count_inc < 16'(MIN_FRAME_LEN));
  assign oversize_hit = (count_q == 16'(MAX_FRAME_LEN));

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked logic so every register samples
    // pre-edge values regardless of statement order.
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_FILL: if (accept && !s_axis.tlast && fill_q == 3'd3) state_d = ST_PASS;
               else if (accept && s_axis.tlast)              state_d = ST_FILL;
      ST_PASS: if (accept && oversize_hit)                   state_d = s_axis.tlast ? ST_FILL : ST_DROP;
               else if (accept && s_axis.tlast)              state_d = ST_FILL;
      ST_DROP: if (accept && s_axis.tlast)                   state_d = ST_FILL;
      default:                                               state_d = ST_FILL;
    endcase
  end

  always_comb begin
    fill_d     = fill_q;
    count_d    = count_q;
    crc_d      = crc_q;
    sticky_d   = sticky_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    m_tvalid_d = m_tvalid_q && !m_axis.tready;
    stat_d     = '0;
    shift_en   = 1'b0;
    if (accept) begin
      case (state_q)
        ST_FILL: begin
          shift_en = 1'b1;
          if (s_axis.tlast) begin
            stat_d.runt = 1'b1;
            fill_d      = 3'd0;
            count_d     = 16'd0;
            crc_d       = CRC32_INIT;
            sticky_d    = 1'b0;
          end else begin
            fill_d   = fill_q + 3'd1;
            count_d  = count_inc;
            crc_d    = crc_next;
            sticky_d = sticky_in;
          end
        end
        ST_PASS: begin
          shift_en   = 1'b1;
          m_tvalid_d = 1'b1;
          m_tdata_d  = dl_q[3];
          m_tlast_d  = 1'b0;
          m_tuser_d  = 1'b0;
          if (oversize_hit || s_axis.tlast) begin
            m_tlast_d = 1'b1;
            fill_d    = 3'd0;
            count_d   = 16'd0;
            crc_d     = CRC32_INIT;
            sticky_d  = 1'b0;
            if (oversize_hit) begin
              m_tuser_d       = 1'b1;
              stat_d.oversize = 1'b1;
            end else begin
              m_tuser_d = bad_fcs | runt | sticky_in;
              if (runt)         stat_d.runt    = 1'b1;
              else if (bad_fcs) stat_d.fcs_err = 1'b1;
              else              stat_d.good    = 1'b1;
            end
          end else begin
            count_d  = count_inc;
            crc_d    = crc_next;
            sticky_d = sticky_in;
          end
        end
        default: ;  // DROP discards everything up to tlast
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q     <= 3'd0;
      count_q    <= 16'd0;
      crc_q      <= CRC32_INIT;
      sticky_q   <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
      stat_q     <= '0;
    end else begin
      fill_q     <= fill_d;
      count_q    <= count_d;
      crc_q      <= crc_d;
      sticky_q   <= sticky_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      stat_q     <= stat_d;
    end
  end

  // NOTE: the delay line has no reset; fill_q alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      dl_q[0] <= s_axis.tdata;
      for (int i = 1; i < 4; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign s_axis.tready   = s_ready;
  assign m_axis.tdata    = m_tdata_q;
  assign m_axis.tvalid   = m_tvalid_q;
  assign m_axis.tlast    = m_tlast_q;
  assign m_axis.tuser    = m_tuser_q;
  assign stat_frame_good = stat_q.good;
  assign stat_fcs_err    = stat_q.fcs_err;
  assign stat_runt       = stat_q.runt;
  assign stat_oversize   = stat_q.oversize;

endmodule

// File: tb/tb_eth_fcs_check.sv
// Self-checking bench for eth_fcs_check: directed frames plus randomized traffic
// compared against a frame-level reference model.
module tb_eth_fcs_check;

  localparam int MAX_LEN = 1518;

  typedef struct packed { logic last; logic user; logic [7:0] data; } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdy = 1'b1;
  bit         rnd_ready = 1'b0;
  bit         gaps = 1'b0;
  logic       drv_valid = 1'b0, drv_last = 1'b0, drv_user = 1'b0;
  logic [7:0] drv_data = 8'h00;
  int         sel = 0;
  int         chk_cnt = 0, pass_cnt = 0, fail_cnt = 0, wait_cycles = 0;

  logic [7:0] fd[$];
  bit         fu[$];
  logic [7:0] saved[$];
  beat_t      obs_q0[$], obs_q1[$], exp_q0[$], exp_q1[$];
  logic [3:0] obs_s0[$], obs_s1[$], exp_s0[$], exp_s1[$];
  logic [3:0] stat0, stat1;   // {oversize, runt, fcs_err, good}

  always #5 clk = ~clk;

  eth_fcs_check_if #(.DATA_WIDTH(8)) s_big ();
  eth_fcs_check_if #(.DATA_WIDTH(8)) m_big ();
  eth_fcs_check_if #(.DATA_WIDTH(8)) s_sm ();
  eth_fcs_check_if #(.DATA_WIDTH(8)) m_sm ();

  assign s_big.tdata  = drv_data;
  assign s_big.tvalid = drv_valid && (sel == 0);
  assign s_big.tlast  = drv_last;
  assign s_big.tuser  = drv_user;
  assign m_big.tready = rdy;
  assign s_sm.tdata   = drv_data;
  assign s_sm.tvalid  = drv_valid && (sel == 1);
  assign s_sm.tlast   = drv_last;
  assign s_sm.tuser   = drv_user;
  assign m_sm.tready  = rdy;

  eth_fcs_check u_dut (
    .clk(clk), .rst(rst), .s_axis(s_big), .m_axis(m_big),
    .stat_frame_good(stat0[0]), .stat_fcs_err(stat0[1]),
    .stat_runt(stat0[2]), .stat_oversize(stat0[3])
  );

  eth_fcs_check #(.MIN_FRAME_LEN(1)) u_dut_min1 (
    .clk(clk), .rst(rst), .s_axis(s_sm), .m_axis(m_sm),
    .stat_frame_good(stat1[0]), .stat_fcs_err(stat1[1]),
    .stat_runt(stat1[2]), .stat_oversize(stat1[3])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitors: record transfers and stat pulses, and check hold-under-stall.
  logic  stall0 = 1'b0, stall1 = 1'b0;
  beat_t hold0, hold1;

  always @(negedge clk) begin
    if (rst) begin
      stall0 <= 1'b0;
      stall1 <= 1'b0;
    end else begin
      if (stall0) check("stall_hold_big", 32'({m_big.tvalid, m_big.tlast, m_big.tuser, m_big.tdata}), 32'({1'b1, hold0}));
      if (stall1) check("stall_hold_min1", 32'({m_sm.tvalid, m_sm.tlast, m_sm.tuser, m_sm.tdata}), 32'({1'b1, hold1}));
      if (m_big.tvalid && m_big.tready) obs_q0.push_back(beat_t'({m_big.tlast, m_big.tuser, m_big.tdata}));
      if (m_sm.tvalid && m_sm.tready)   obs_q1.push_back(beat_t'({m_sm.tlast, m_sm.tuser, m_sm.tdata}));
      if (stat0 != 4'd0) obs_s0.push_back(stat0);
      if (stat1 != 4'd0) obs_s1.push_back(stat1);
      stall0 <= m_big.tvalid && !m_big.tready;
      stall1 <= m_sm.tvalid && !m_sm.tready;
      hold0  <= beat_t'({m_big.tlast, m_big.tuser, m_big.tdata});
      hold1  <= beat_t'({m_sm.tlast, m_sm.tuser, m_sm.tdata});
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Standard Ethernet CRC-32 (with final inversion) over the first n bytes of fd.
  function automatic logic [31:0] crc_std(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ 32'(fd[i]);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_exp(input int which, input beat_t b);
    if (which == 0) exp_q0.push_back(b);
    else            exp_q1.push_back(b);
  endtask

  // Reference model: what a whole frame must produce, from its length, FCS and error flags.
  task automatic model_frame(input int which, input int min_len);
    int         n;
    bit         any_u, ok, rn, lst;
    logic [3:0] st;
    n = fd.size();
    any_u = 1'b0;
    foreach (fu[i]) any_u |= fu[i];
    if (n <= 4) begin
      st = 4'd4;
    end else if (n > MAX_LEN) begin
      for (int i = 0; i <= MAX_LEN - 4; i++) begin
        lst = (i == MAX_LEN - 4);
        push_exp(which, beat_t'({lst, lst, fd[i]}));
      end
      st = 4'd8;
    end else begin
      ok = (crc_std(n - 4) == {fd[n-1], fd[n-2], fd[n-3], fd[n-4]});
      rn = (n < min_len);
      for (int i = 0; i < n - 4; i++) begin
        lst = (i == n - 5);
        push_exp(which, beat_t'({lst, lst && (!ok || rn || any_u), fd[i]}));
      end
      st = rn ? 4'd4 : (!ok ? 4'd2 : 4'd1);
    end
    if (which == 0) exp_s0.push_back(st);
    else            exp_s1.push_back(st);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    int   waited;
    logic ok;
    waited = 0;
    drv_data = d; drv_last = l; drv_user = u; drv_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = (sel == 0) ? s_big.tready : s_sm.tready;
      @(posedge clk);
      #1;
      if (ok) break;
      waited++;
      wait_cycles++;
      if (waited > 5000) begin
        check("accept_timeout", waited, 0);
        break;
      end
    end
    drv_valid = 1'b0;
  endtask

  task automatic make_frame(input int n, input bit good_fcs, input int user_at);
    logic [31:0] c;
    fd.delete();
    fu.delete();
    for (int i = 0; i < n; i++) begin
      fd.push_back(8'($urandom_range(0, 255)));
      fu.push_back(i == user_at);
    end
    if (good_fcs && n >= 5) begin
      c = crc_std(n - 4);
      fd[n-4] = c[7:0];  fd[n-3] = c[15:8];
      fd[n-2] = c[23:16]; fd[n-1] = c[31:24];
    end
  endtask

  task automatic send_frame(input int which);
    sel = which;
    model_frame(which, (which == 0) ? 64 : 1);
    for (int i = 0; i < fd.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_beat(fd[i], i == fd.size() - 1, fu[i]);
    end
  endtask

  task automatic clear_all();
    obs_q0.delete(); obs_q1.delete(); exp_q0.delete(); exp_q1.delete();
    obs_s0.delete(); obs_s1.delete(); exp_s0.delete(); exp_s1.delete();
  endtask

  task automatic drain_compare(input int which, input string tag);
    beat_t      o[$], e[$];
    logic [3:0] os[$], es[$];
    int         t;
    t = 0;
    while (t < 400 && ((which == 0) ?
           (obs_q0.size() < exp_q0.size() || obs_s0.size() < exp_s0.size()) :
           (obs_q1.size() < exp_q1.size() || obs_s1.size() < exp_s1.size()))) begin
      idle(1);
      t++;
    end
    idle(4);
    if (which == 0) begin o = obs_q0; e = exp_q0; os = obs_s0; es = exp_s0; end
    else            begin o = obs_q1; e = exp_q1; os = obs_s1; es = exp_s1; end
    check({tag, " beat_count"}, o.size(), e.size());
    for (int i = 0; i < e.size() && i < o.size(); i++) check({tag, " beat"}, 32'(o[i]), 32'(e[i]));
    check({tag, " stat_count"}, os.size(), es.size());
    for (int i = 0; i < es.size() && i < os.size(); i++) check({tag, " stat"}, 32'(os[i]), 32'(es[i]));
    clear_all();
  endtask

  initial begin
    // Reset values
    idle(3);
    check("rst m_tvalid", m_big.tvalid, 0);
    check("rst m_tdata", m_big.tdata, 0);
    check("rst m_tlast_tuser", {m_big.tlast, m_big.tuser}, 0);
    check("rst stats", stat0, 0);
    check("rst s_tready", s_big.tready, 1);
    check("rst min1 m_tvalid", m_sm.tvalid, 0);
    rst = 1'b0;
    idle(2);

    // Known-answer frame "123456789" + FCS on the MIN_FRAME_LEN=1 instance
    fd = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    fu.delete();
    for (int i = 0; i < 13; i++) fu.push_back(1'b0);
    send_frame(1);
    drain_compare(1, "kat_good");
    fd[12] = 8'hCA;
    send_frame(1);
    drain_compare(1, "kat_bad_fcs");

    // Minimum-length good frame, back-to-back with a second one (no bubble)
    wait_cycles = 0;
    make_frame(64, 1'b1, -1);
    saved = fd;
    send_frame(0);
    make_frame(64, 1'b1, -1);
    send_frame(0);
    check("back_to_back stalls", wait_cycles, 0);
    drain_compare(0, "good64x2");

    // Truncated 3-byte frame, then the full frame again
    fd = saved;
    while (fd.size() > 3) void'(fd.pop_back());
    fu.delete();
    for (int i = 0; i < 3; i++) fu.push_back(1'b0);
    send_frame(0);
    drain_compare(0, "runt3");
    fd = saved;
    fu.delete();
    for (int i = 0; i < 64; i++) fu.push_back(1'b0);
    send_frame(0);
    drain_compare(0, "after_runt");

    // Oversize frame: truncated output, remaining bytes swallowed without stalls
    wait_cycles = 0;
    make_frame(1600, 1'b0, -1);
    send_frame(0);
    check("oversize drop stalls", wait_cycles, 0);
    drain_compare(0, "oversize1600");

    // Input tuser error on an otherwise good frame
    make_frame(80, 1'b1, 30);
    send_frame(0);
    drain_compare(0, "tuser_err");

    // Randomized mixed traffic with output back-pressure and input gaps
    rnd_ready = 1'b1;
    gaps = 1'b1;
    for (int f = 0; f < 100; f++) begin
      int r, n;
      r = $urandom_range(0, 99);
      if (r < 10)      n = $urandom_range(1, 4);
      else if (r < 25) n = $urandom_range(5, 63);
      else if (r < 98) n = $urandom_range(64, 160);
      else             n = $urandom_range(1519, 1522);
      make_frame(n, $urandom_range(0, 9) < 7, ($urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1);
      send_frame(0);
      drain_compare(0, "random");
    end
    rnd_ready = 1'b0;
    gaps = 1'b0;
    idle(2);

    // Reset in the middle of a frame
    make_frame(40, 1'b1, -1);
    sel = 0;
    for (int i = 0; i < 20; i++) send_beat(fd[i], 1'b0, 1'b0);
    check("pre_reset m_tvalid", m_big.tvalid, 1);
    rst = 1'b1;
    #1;
    check("mid_reset m_tvalid", m_big.tvalid, 0);
    check("mid_reset m_tlast_tuser", {m_big.tlast, m_big.tuser}, 0);
    check("mid_reset stats", stat0, 0);
    idle(2);
    rst = 1'b0;
    clear_all();
    idle(2);
    make_frame(64, 1'b1, -1);
    send_frame(0);
    drain_compare(0, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
